// File: rtl/register_array_pq_tagged.sv
// Register-array priority queue with valid-tagged key/payload entries and odd-even settling.
// Optional high-water-mark output o_hwm is enabled by defining REGISTER_ARRAY_PQ_HWM_EN.
module register_array_pq_tagged #(
  parameter int unsigned QUEUE_SIZE = 8,
  parameter int unsigned KEY_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          MIN_FIRST  = 1'b0,
  parameter bit          ENQ_ENA    = 1'b1
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_wrt,
  input  logic                          i_read,
  input  logic [KEY_WIDTH-1:0]          i_key,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_valid,
  output logic [KEY_WIDTH-1:0]          o_key,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [$clog2(QUEUE_SIZE):0]   o_count,
  output logic                          o_sorted,
  output logic                          o_err
`ifdef REGISTER_ARRAY_PQ_HWM_EN
  ,
  output logic [$clog2(QUEUE_SIZE):0]   o_hwm
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_SIZE) + 1;

  typedef struct packed {
    logic                  valid;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t         q     [QUEUE_SIZE];
  entry_t         s1    [QUEUE_SIZE];
  entry_t         s2    [QUEUE_SIZE];
  logic [CW-1:0]  count_q, count_d;
  logic           phase_q;
  logic [1:0]     clean_q, clean_d;
  logic           err_q, err_d;
  logic           accepted, swap_now, found;
  logic           is_full, is_empty;
  logic           do_enq, do_deq, do_rep;

  // Invalid entries always lose; equal keys never win, which keeps ties stable.
  function automatic logic better(input entry_t a, input entry_t b);
    if (!a.valid) return 1'b0;
    if (!b.valid) return 1'b1;
    return MIN_FIRST ? (a.key < b.key) : (a.key > b.key);
  endfunction

  assign is_full  = (count_q == CW'(QUEUE_SIZE));
  assign is_empty = (count_q == CW'(0));
  assign do_enq   = ENQ_ENA & i_wrt & ~i_read;
  assign do_deq   = ~i_wrt & i_read;
  assign do_rep   = i_wrt & i_read;

  // Stage 1: apply the decoded request to the current array.
  always_comb begin
    s1       = q;
    count_d  = count_q;
    accepted = 1'b0;
    err_d    = 1'b0;
    found    = 1'b0;
    if (do_rep) begin
      s1[0]    = '{valid: 1'b1, key: i_key, data: i_data};
      accepted = 1'b1;
      if (is_empty) count_d = CW'(1);
    end else if (do_enq) begin
      if (is_full) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < QUEUE_SIZE; i++) begin
          if (!found && !q[i].valid) begin
            s1[i] = '{valid: 1'b1, key: i_key, data: i_data};
            found = 1'b1;
          end
        end
        count_d  = count_q + CW'(1);
        accepted = 1'b1;
      end
    end else if (do_deq) begin
      if (is_empty) begin
        err_d = 1'b1;
      end else begin
        for (int i = 0; i < QUEUE_SIZE - 1; i++) s1[i] = q[i+1];
        s1[QUEUE_SIZE-1] = '0;
        count_d  = count_q - CW'(1);
        accepted = 1'b1;
      end
    end else if (i_wrt) begin
      // Push request while pure enqueue is disabled.
      err_d = 1'b1;
    end
  end

  // Stage 2: one compare-exchange pass over disjoint pairs chosen by phase.
  always_comb begin
    s2       = s1;
    swap_now = 1'b0;
    for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
      if (i[0] == phase_q && better(s1[i+1], s1[i])) begin
        s2[i]    = s1[i+1];
        s2[i+1]  = s1[i];
        swap_now = 1'b1;
      end
    end
  end

  always_comb begin
    clean_d = clean_q;
    if (accepted || swap_now) clean_d = 2'd0;
    else if (clean_q != 2'd2) clean_d = clean_q + 2'd1;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= '0;
      count_q <= '0;
      phase_q <= 1'b0;
      clean_q <= 2'd2;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) q[i] <= s2[i];
      count_q <= count_d;
      phase_q <= ~phase_q;
      clean_q <= clean_d;
      err_q   <= err_d;
    end
  end

`ifdef REGISTER_ARRAY_PQ_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge i_CLK) begin
    if (i_RST) hwm_q <= '0;
    else if (count_d > hwm_q) hwm_q <= count_d;
  end

  assign o_hwm = hwm_q;
`endif

  assign o_full   = is_full;
  assign o_empty  = is_empty;
  assign o_valid  = q[0].valid;
  assign o_key    = q[0].key;
  assign o_data   = q[0].data;
  assign o_count  = count_q;
  assign o_sorted = (clean_q == 2'd2);
  assign o_err    = err_q;

endmodule
